// File: rtl/alu_pkg.sv
// Shared ALU library types: divider FSM states and counter sizing.
// Used by restoring_divider (optional DIV_ZERO_CHECK_EN build).
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/borrow_subtractor.sv
// Ripple borrow-chain subtractor built from full-subtractor cells.
// Computes i_minuend - i_subtrahend with a final borrow-out.
module borrow_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_minuend,
  input  logic [N-1:0] i_subtrahend,
  output logic [N-1:0] o_difference,
  output logic         o_borrow
);

  logic [N:0] w_b;

  assign w_b[0] = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_cell
    logic w_x;
    assign w_x = i_minuend[g] ^ i_subtrahend[g];
    assign o_difference[g] = w_x ^ w_b[g];
    assign w_b[g+1] = (~i_minuend[g] & i_subtrahend[g])
                    | (~w_x & w_b[g]);
  end

  assign o_borrow = w_b[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional zero-divisor fast path and flag: define DIV_ZERO_CHECK_EN.
module restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic             DIV_ZERO
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_e           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic             w_last;
  logic             w_unused;

  assign w_partial = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};

  borrow_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .i_minuend   (w_partial),
    .i_subtrahend({1'b0, r_dvs}),
    .o_difference(w_diff),
    .o_borrow    (w_borrow)
  );

  // Restore on borrow: keep the shifted partial, shift in a 0.
  assign w_rem_nxt = w_borrow ? w_partial : w_diff;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // Remainder is always below the divisor, so its top bit stays zero.
  assign w_unused = ^{r_rem[WIDTH], r_quo[WIDTH-1], w_rem_nxt[WIDTH]};

`ifdef DIV_ZERO_CHECK_EN
  logic r_dz;
  assign DIV_ZERO = r_dz;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
`ifdef DIV_ZERO_CHECK_EN
      r_dz    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE, FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (START) begin
            r_dvd <= DIVIDEND;
            r_dvs <= DIVISOR;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
`ifdef DIV_ZERO_CHECK_EN
            r_dz  <= (DIVISOR == '0);
            if (DIVISOR == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
              r_q     <= '1;
              r_r     <= DIVIDEND;
            end else begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end
`else
            r_state <= RUN;
            r_busy  <= 1'b1;
`endif
          end
        end
        RUN: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_quo_nxt;
            r_r     <= w_rem_nxt[WIDTH-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign QUOTIENT  = r_q;
  assign REMAINDER = r_r;

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider for the arithmetic-logic-unit library. It is the inverse companion of the ripple adder/subtractor: the adder composes a sum, and this block decomposes a dividend into quotient and remainder by repeated shift-and-subtract. It produces one quotient bit per clock through a start/busy/done handshake. It sits beside the combinational adder units and reuses a borrow-chain subtractor.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits (valid range 2..32)
- CLK  input  1  single clock; all state changes on the rising edge
- RST_N  input  1  reset, synchronous and active-low
- START  input  1  request a division; sampled only when the FSM accepts it
- DIVIDEND  input  WIDTH  unsigned dividend; sampled with an accepted START
- DIVISOR  input  WIDTH  unsigned divisor; sampled with an accepted START
- BUSY  output  1  high while iterating
- DONE  output  1  one-cycle pulse; QUOTIENT and REMAINDER are valid
- QUOTIENT  output  WIDTH  result quotient; holds until the next completion
- REMAINDER  output  WIDTH  result remainder; holds until the next completion
- DIV_ZERO  output  1  divide-by-zero flag; present only when DIV_ZERO_CHECK_EN is defined

## Operation
- FSM states: IDLE, RUN, FINISH.
- IDLE: START=1 latches the operands, clears the partial remainder (WIDTH+1 bits) and the iteration counter, and moves to RUN. START=0 stays in IDLE.
- RUN: one iteration per cycle, for exactly WIDTH cycles:
  - partial = {rem[WIDTH-1:0], dividend-shift MSB}; diff = partial − {1'b0, divisor}.
  - No borrow: rem = diff and a quotient bit of 1 is shifted in.
  - Borrow: rem = partial and a quotient bit of 0 is shifted in.
- After the WIDTH-th iteration the FSM enters FINISH. QUOTIENT and REMAINDER load on that same edge.
- FINISH: lasts one cycle with DONE=1. The FSM then returns to IDLE.
  - START=1 in FINISH is accepted exactly as in IDLE, which allows back-to-back divisions.
- START in RUN is ignored. Operands are not re-sampled in RUN.
- Divide by zero without the check: the iterations run normally, giving QUOTIENT = all ones and REMAINDER = DIVIDEND.
- The counter is a clog2(WIDTH+1)-bit up-counter. The terminal count is WIDTH−1; there is no wrap-around use.

## Timing
- Reset (RST_N=0 at an edge) forces:
  - state = IDLE
  - BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_ZERO=0
  - counter = 0
- Reset mid-RUN aborts the division. No DONE is produced for the aborted operation.
- START sampled at edge k:
  - BUSY=1 from after edge k through edge k+WIDTH.
  - DONE=1 for the single cycle after edge k+WIDTH.
  - Latency is WIDTH cycles from START to DONE.
- BUSY and DONE are never high together.
- Throughput with back-to-back START: one result every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: DIV_ZERO_CHECK_EN.
- Defined:
  - An accepted START with DIVISOR=0 goes directly to FINISH, with QUOTIENT = all ones, REMAINDER = DIVIDEND and DIV_ZERO=1.
  - DONE follows after one cycle, and BUSY stays 0.
  - DIV_ZERO holds until the next accepted START, which clears it.
- Undefined:
  - The DIV_ZERO port and its logic are absent.
  - A zero divisor takes the full WIDTH-cycle path with the same numeric result.

## Structure
- Shared package (alu_pkg): the state enum (IDLE, RUN, FINISH) and a clog2-based counter width function.
- Sub-module BORROW_SUBTRACTOR: a (WIDTH+1)-bit ripple subtractor built from full-subtractor cells. Ports: minuend, subtrahend, difference, borrow-out. It is instantiated once for the iteration datapath.

## Test plan
- WIDTH=4, 13÷4, START at edge k:
  - QUOTIENT=3, REMAINDER=1.
  - DONE only in the cycle after edge k+4, and BUSY high for 4 cycles.
- 15÷1 gives Q=15, R=0. 7÷9 gives Q=0, R=7. 0÷5 gives Q=0, R=0.
- Back-to-back: 13÷4, with START held high during FINISH, then 14÷3:
  - Results 3/1 and then 4/2.
  - The second DONE comes 5 cycles after the first.
- START pulsed mid-RUN with different operands: ignored, and the first result 13÷4 = 3/1 is unchanged.
- Reset asserted at the 2nd RUN cycle: all outputs are 0 next cycle, no DONE appears, and a new START of 9÷2 gives 4/1.
- 9÷0:
  - Without the macro: Q=15, R=9, DONE after 4 cycles.
  - With DIV_ZERO_CHECK_EN: DONE one cycle after START, DIV_ZERO=1, Q=15, R=9, BUSY never high.
